debug_tx_unit: RTL and testbench

DEBUG_TX_UNIT -- requirements
Module: debug_tx_unit

---
 rtl/debug_tx_unit.sv | 170 +++++++++++++++++
 tb/tb_debug_tx_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_unit
//  Description : Streams a processor debug snapshot (PC, cycle count,
//                register file, data-memory window) to a byte-wide UART
//                transmitter, most significant byte of each word first.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_unit #(
  parameter int NBITS           = 32,
  parameter int NREGS           = 32,
  parameter int REG_ADDR_LENGTH = 5,
  parameter int DM_WORDS        = 16,
  parameter int DM_ADDR_LENGTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       send_flag,
  input  logic [NBITS-1:0]           pc_value,
  input  logic [NBITS-1:0]           cycle_count,
  output logic [REG_ADDR_LENGTH-1:0] reg_addr,
  input  logic [NBITS-1:0]           reg_data,
  output logic [DM_ADDR_LENGTH-1:0]  dm_addr,
  input  logic [NBITS-1:0]           dm_data,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       send_done
);

  localparam int C_WORDS  = 2 + NREGS + DM_WORDS;
  localparam int C_NBYTES = NBITS / 8;
  localparam int C_IDX_W  = (C_WORDS > 2) ? $clog2(C_WORDS) : 1;
  localparam int C_BC_W   = (C_NBYTES > 1) ? $clog2(C_NBYTES) : 1;
  localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(C_WORDS - 1);
  localparam logic [C_BC_W-1:0]  C_LAST_BYTE = C_BC_W'(C_NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                     state_q;
  logic [C_IDX_W-1:0]         idx_q;
  logic [C_BC_W-1:0]          byte_cnt_q;
  logic [NBITS-1:0]           shift_q;
  logic                       flag_q;
  logic [REG_ADDR_LENGTH-1:0] reg_addr_q;
  logic [DM_ADDR_LENGTH-1:0]  dm_addr_q;
  logic [7:0]                 tx_data_q;
  logic                       tx_start_q;
  logic                       send_done_q;

  logic [C_IDX_W-1:0]         idx_next_d;
  logic [REG_ADDR_LENGTH-1:0] reg_addr_d;
  logic [DM_ADDR_LENGTH-1:0]  dm_addr_d;
  logic [NBITS-1:0]           src_word_d;
  logic [NBITS-1:0]           shift_next_d;

  assign idx_next_d   = idx_q + C_IDX_W'(1);
  assign shift_next_d = shift_q << 8;

  // Read addresses for the next word, presented while LOAD is active so that
  // the one-cycle read latency lands the data in FETCH.
  always_comb begin
    reg_addr_d = '0;
    dm_addr_d  = '0;
    if (int'(idx_next_d) >= 2 && int'(idx_next_d) < NREGS + 2) begin
      reg_addr_d = REG_ADDR_LENGTH'(int'(idx_next_d) - 2);
    end else if (int'(idx_next_d) >= NREGS + 2) begin
      dm_addr_d = DM_ADDR_LENGTH'(int'(idx_next_d) - 2 - NREGS);
    end
  end

  // Source word for the current index: PC, cycle count, register or memory.
  always_comb begin
    src_word_d = pc_value;
    if (idx_q == C_IDX_W'(1)) begin
      src_word_d = cycle_count;
    end else if (int'(idx_q) >= 2 && int'(idx_q) < NREGS + 2) begin
      src_word_d = reg_data;
    end else if (int'(idx_q) >= NREGS + 2) begin
      src_word_d = dm_data;
    end
  end

  // Dump sequencer; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      flag_q      <= 1'b0;
      reg_addr_q  <= '0;
      dm_addr_q   <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      send_done_q <= 1'b0;
    end else begin
      flag_q <= send_flag;
      case (state_q)
        S_IDLE: begin
          // Word 0 is the PC, so both read addresses stay at 0.
          if (send_flag && !flag_q) begin
            idx_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          shift_q    <= src_word_d;
          byte_cnt_q <= '0;
          tx_data_q  <= src_word_d[NBITS-1 -: 8];
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          tx_start_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (byte_cnt_q != C_LAST_BYTE) begin
              shift_q    <= shift_next_d;
              byte_cnt_q <= byte_cnt_q + C_BC_W'(1);
              tx_data_q  <= shift_next_d[NBITS-1 -: 8];
              tx_start_q <= 1'b1;
              state_q    <= S_SEND;
            end else if (idx_q != C_LAST_IDX) begin
              idx_q      <= idx_next_d;
              reg_addr_q <= reg_addr_d;
              dm_addr_q  <= dm_addr_d;
              state_q    <= S_LOAD;
            end else begin
              reg_addr_q  <= '0;
              dm_addr_q   <= '0;
              send_done_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          send_done_q <= 1'b0;
          idx_q       <= '0;
          reg_addr_q  <= '0;
          dm_addr_q   <= '0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reg_addr  = reg_addr_q;
  assign dm_addr   = dm_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign send_done = send_done_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_tx_unit
//  Description : Directed self-checking bench for debug_tx_unit with a UART
//                responder, synchronous register/memory read models and a
//                byte collector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_tx_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_flag = 1'b0;
  logic [31:0] pc_value = 32'h0;
  logic [31:0] cycle_count = 32'h0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data = 32'h0;
  logic [31:0] dm_addr;
  logic [31:0] dm_data = 32'h0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        send_done;

  logic        done_u = 1'b0;
  logic        done_s = 1'b0;
  assign tx_done = done_u | done_s;

  int errors = 0;
  int checks = 0;
  logic [7:0] bytes_q[$];
  int done_cnt = 0;

  debug_tx_unit dut (
    .clk         (clk),
    .reset       (reset),
    .send_flag   (send_flag),
    .pc_value    (pc_value),
    .cycle_count (cycle_count),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .dm_addr     (dm_addr),
    .dm_data     (dm_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .send_done   (send_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file and data memory contents.
  always @(posedge clk) begin
    reg_data <= 32'hA500_0000 + {27'd0, reg_addr};
    dm_data  <= 32'h0000_BE00 + dm_addr;
  end

  // UART responder: tx_done pulse 3 cycles after each tx_start.
  always begin
    @(posedge clk);
    if (tx_start === 1'b1) begin
      repeat (2) @(posedge clk);
      #1 done_u = 1'b1;
      @(posedge clk);
      #1 done_u = 1'b0;
    end
  end

  // Byte and completion collector.
  always @(posedge clk) begin
    if (tx_start === 1'b1) bytes_q.push_back(tx_data);
    if (send_done === 1'b1) done_cnt = done_cnt + 1;
  end

  function automatic logic [7:0] exp_byte(input int n, input logic [31:0] pc,
                                          input logic [31:0] cc);
    int w;
    int b;
    logic [31:0] word;
    w = n / 4;
    b = n % 4;
    if (w == 0)      word = pc;
    else if (w == 1) word = cc;
    else if (w < 34) word = 32'hA500_0000 + 32'(w - 2);
    else             word = 32'h0000_BE00 + 32'(w - 34);
    return 8'(word >> (8 * (3 - b)));
  endfunction

  function automatic logic [7:0] got_byte(input int n);
    if (n < bytes_q.size()) return bytes_q[n];
    return 8'hxx;
  endfunction

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int c = 0;
    while (bytes_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (bytes_q.size() >= n);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start = done_cnt;
    int c = 0;
    while (done_cnt == start && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (done_cnt != start);
  endtask

  task automatic restart_dump();
    send_flag = 1'b0;
    repeat (3) @(negedge clk);
    bytes_q.delete();
    done_cnt = 0;
    send_flag = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (send_done !== 1'b0) begin errors++; $display("FAIL reset_send_done got=%b exp=0", send_done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_reg_addr got=%0d exp=0", reg_addr); end
    checks++; if (dm_addr !== 32'd0) begin errors++; $display("FAIL reset_dm_addr got=%0d exp=0", dm_addr); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_dump();
    bit ok;
    int bad;
    logic [7:0] first8 [8];
    first8 = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h1F};
    pc_value = 32'h0000_0040;
    cycle_count = 32'h0000_001F;
    restart_dump();
    wait_bytes(1, 100, ok);
    pc_value = 32'hFFFF_FFFF;   // captured word must not change
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got=none exp=send_done"); end
    checks++; if (bytes_q.size() != 200) begin errors++; $display("FAIL full_byte_count got=%0d exp=200", bytes_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_byte(i) !== first8[i]) begin errors++; $display("FAIL full_first8[%0d] got=%h exp=%h", i, got_byte(i), first8[i]); end
    end
    checks++; if ({got_byte(8), got_byte(9), got_byte(10), got_byte(11)} !== 32'hA500_0000) begin
      errors++; $display("FAIL full_idx2 got=%h%h%h%h exp=A5000000", got_byte(8), got_byte(9), got_byte(10), got_byte(11)); end
    checks++; if ({got_byte(132), got_byte(133), got_byte(134), got_byte(135)} !== 32'hA500_001F) begin
      errors++; $display("FAIL full_idx33 got=%h%h%h%h exp=A500001F", got_byte(132), got_byte(133), got_byte(134), got_byte(135)); end
    checks++; if ({got_byte(196), got_byte(197), got_byte(198), got_byte(199)} !== 32'h0000_BE0F) begin
      errors++; $display("FAIL full_last4 got=%h%h%h%h exp=0000BE0F", got_byte(196), got_byte(197), got_byte(198), got_byte(199)); end
    bad = -1;
    for (int i = 0; i < 200; i++)
      if (bad < 0 && got_byte(i) !== exp_byte(i, 32'h40, 32'h1F)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL full_stream byte=%0d got=%h exp=%h", bad, got_byte(bad), exp_byte(bad, 32'h40, 32'h1F)); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (reg_addr !== 5'd0 || dm_addr !== 32'd0) begin errors++; $display("FAIL full_idle_addr got=%0d/%0d exp=0/0", reg_addr, dm_addr); end
    pc_value = 32'h0000_0040;
  endtask

  task automatic test_hold_flag();
    int n = bytes_q.size();
    int d = done_cnt;
    repeat (1000) @(negedge clk);
    checks++; if (bytes_q.size() != n) begin errors++; $display("FAIL hold_no_retrigger got=%0d exp=%0d", bytes_q.size(), n); end
    checks++; if (done_cnt != d) begin errors++; $display("FAIL hold_no_done got=%0d exp=%0d", done_cnt, d); end
  endtask

  task automatic test_spurious_done();
    bit ok;
    int bad;
    restart_dump();
    for (int k = 0; k < 3; k++) begin
      int c = 0;
      while (tx_start !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      done_s = 1'b1;
      @(posedge clk);
      #1 done_s = 1'b0;
      @(negedge clk);
    end
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL spur_done_timeout got=none exp=send_done"); end
    checks++; if (bytes_q.size() != 200) begin errors++; $display("FAIL spur_byte_count got=%0d exp=200", bytes_q.size()); end
    bad = -1;
    for (int i = 0; i < 200; i++)
      if (bad < 0 && got_byte(i) !== exp_byte(i, 32'h40, 32'h1F)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL spur_stream byte=%0d got=%h exp=%h", bad, got_byte(bad), exp_byte(bad, 32'h40, 32'h1F)); end
    repeat (10) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL spur_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    restart_dump();
    wait_bytes(50, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach50 got=%0d exp=50", bytes_q.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0 || send_done !== 1'b0) begin errors++; $display("FAIL rst_outputs_low got=%b%b exp=00", tx_start, send_done); end
    checks++; if (tx_data !== 8'h00 || reg_addr !== 5'd0 || dm_addr !== 32'd0) begin
      errors++; $display("FAIL rst_regs_clear got=%h/%0d/%0d exp=00/0/0", tx_data, reg_addr, dm_addr); end
    send_flag = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt); end
    checks++; if (bytes_q.size() != 50) begin errors++; $display("FAIL rst_stopped got=%0d exp=50", bytes_q.size()); end
    restart_dump();
    wait_bytes(8, 200, ok);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_byte(i) !== exp_byte(i, 32'h40, 32'h1F)) begin errors++; $display("FAIL rst_restart[%0d] got=%h exp=%h", i, got_byte(i), exp_byte(i, 32'h40, 32'h1F)); end
    end
    wait_done(3000, ok);
    checks++; if (!ok || bytes_q.size() != 200) begin errors++; $display("FAIL rst_restart_total got=%0d exp=200", bytes_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    restart_dump();
    wait_bytes(20, 500, ok);
    send_flag = 1'b0;
    repeat (3) @(negedge clk);
    send_flag = 1'b1;
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout got=none exp=send_done"); end
    bad = -1;
    for (int i = 0; i < 200; i++)
      if (bad < 0 && got_byte(i) !== exp_byte(i, 32'h40, 32'h1F)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_stream byte=%0d got=%h exp=%h", bad, got_byte(bad), exp_byte(bad, 32'h40, 32'h1F)); end
    repeat (50) @(negedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (bytes_q.size() != 200) begin errors++; $display("FAIL b2b_byte_count got=%0d exp=200", bytes_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_hold_flag();
    test_spurious_done();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
